// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage pipeline.
//
// Owns the PC, issues level-sensitive requests to a variable-latency
// instruction memory and owns the IF/ID pipeline register. A response that
// lands while the hazard unit is stalling is parked in a one-entry skid
// buffer. A flush that arrives while a request is outstanding must let that
// stale request finish before the address may change, so the stale address
// is kept in drop_addr until the memory answers.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   pc_write_i       0 = hold PC (hazard unit)
//   IFID_write_i     0 = hold IF/ID (hazard unit)
//   flush_i          branch taken in ID: squash IF/ID, redirect PC
//   branch_target_i  redirect address, used when flush_i=1
//   imem_req_o       fetch request (level)
//   imem_addr_o      fetch address
//   imem_ready_i     response valid this cycle
//   imem_data_i      instruction word
//   pc_o/instr_o/valid_o  IF/ID register contents
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        IFID_write_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    // 2'b11 is unreachable; it falls into the default arm and acts as S_REQ.
    typedef enum logic [1:0] {
        S_REQ    = 2'b00,
        S_BUF    = 2'b01,
        S_DROP   = 2'b10,
        S_UNUSED = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        stall_s;

    assign stall_s = ~pc_write_i | ~IFID_write_i;

    // Next-state and register update logic; everything holds unless a rule fires.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        skid_d       = skid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        case (state_q)
            S_BUF: begin
                if (flush_i) begin
                    // Flush beats stall; the parked word is simply abandoned.
                    pc_d         = branch_target_i;
                    ifid_pc_d    = 32'h0000_0000;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end else if (!stall_s) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = skid_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_REQ;
                end else begin
                    state_d      = S_BUF;
                end
            end

            S_DROP: begin
                if (imem_ready_i) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DROP;
                end

                if (flush_i) begin
                    // A second flush only retargets pc; drop_addr keeps the
                    // address still on the bus.
                    pc_d         = branch_target_i;
                    ifid_pc_d    = 32'h0000_0000;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end else if (imem_ready_i && IFID_write_i) begin
                    ifid_pc_d    = 32'h0000_0000;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end else begin
                    ifid_valid_d = ifid_valid_q;
                end
            end

            default: begin
                if (imem_ready_i && flush_i) begin
                    pc_d         = branch_target_i;
                    ifid_pc_d    = 32'h0000_0000;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end else if (imem_ready_i && !stall_s) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_data_i;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_REQ;
                end else if (imem_ready_i) begin
                    skid_d       = imem_data_i;
                    state_d      = S_BUF;
                end else if (flush_i) begin
                    drop_addr_d  = pc_q;
                    pc_d         = branch_target_i;
                    ifid_pc_d    = 32'h0000_0000;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    state_d      = S_DROP;
                end else if (IFID_write_i) begin
                    ifid_pc_d    = 32'h0000_0000;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    state_d      = S_REQ;
                end else begin
                    state_d      = S_REQ;
                end
            end
        endcase
    end

    // State, PC, skid, drop address and IF/ID registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_addr_q  <= 32'h0000_0000;
            skid_q       <= 32'h0000_0000;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            skid_q       <= skid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Memory request decode; reset kills the request immediately.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        if (rst_i) begin
            imem_req_o = 1'b0;
        end else begin
            case (state_q)
                S_BUF: begin
                    imem_req_o = 1'b0;
                end
                S_DROP: begin
                    imem_req_o  = 1'b1;
                    imem_addr_o = drop_addr_q;
                end
                default: begin
                    imem_req_o = 1'b1;
                end
            endcase
        end
    end

    assign pc_o    = ifid_pc_q;
    assign instr_o = ifid_instr_q;
    assign valid_o = ifid_valid_q;

endmodule
